// File: rtl/modsmul_pipe.sv
// Pipelined modular small-constant multiplier: out = (k * a) mod P, shift-and-add MSB-first.
// Optional modular negation stage enabled by defining MODSMUL_NEG_EN.
module modsmul_pipe #(
    parameter int             W     = 381,
    parameter logic [W-1:0]   P     = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab,
    parameter int             KBITS = 2,
    parameter int             TAGW  = 6,
    parameter int             THRES = 160
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [KBITS-1:0] in_k,
    input  logic             in_neg,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [TAGW-1:0]  out_tag
);

`ifdef MODSMUL_NEG_EN
    localparam int NS = 2 * KBITS + 2;
`else
    localparam int NS = 2 * KBITS + 1;
    logic unused_neg_s;
    assign unused_neg_s = in_neg;
`endif
    localparam int unused_thres = THRES;

    // One conditional subtraction suffices because both operands are below P.
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] sum;
        logic [W:0] diff;
        sum  = {1'b0, x} + {1'b0, y};
        diff = sum - {1'b0, P};
        return diff[W] ? sum[W-1:0] : diff[W-1:0];
    endfunction

    logic             vld_r [NS];
    logic [W-1:0]     acc_r [NS];
    logic [W-1:0]     a_r   [NS];
    logic [KBITS-1:0] k_r   [NS];
    logic [TAGW-1:0]  tag_r [NS];
    logic             vld_s [NS];
    logic [W-1:0]     acc_s [NS];
    logic [W-1:0]     a_s   [NS];
    logic [KBITS-1:0] k_s   [NS];
    logic [TAGW-1:0]  tag_s [NS];
`ifdef MODSMUL_NEG_EN
    logic             neg_r [NS];
    logic             neg_s [NS];
`endif
    logic             stall_s;

    assign out_valid = vld_r[NS-1];
    assign out_data  = acc_r[NS-1];
    assign out_tag   = tag_r[NS-1];
    assign stall_s   = out_valid & ~out_ready;
    assign in_ready  = ~stall_s;

    // Next-state of every stage; k is shifted left at each add stage so its MSB is the bit under test.
    always_comb begin
        for (int j = 0; j < NS; j++) begin
            vld_s[j] = 1'b0;
            acc_s[j] = {W{1'b0}};
            a_s[j]   = {W{1'b0}};
            k_s[j]   = {KBITS{1'b0}};
            tag_s[j] = {TAGW{1'b0}};
`ifdef MODSMUL_NEG_EN
            neg_s[j] = 1'b0;
`endif
        end
        if (in_valid) begin
            vld_s[0] = 1'b1;
            a_s[0]   = in_a;
            k_s[0]   = in_k;
            tag_s[0] = in_tag;
`ifdef MODSMUL_NEG_EN
            neg_s[0] = in_neg;
`endif
        end else begin
            vld_s[0] = 1'b0;
        end
        for (int j = 1; j <= 2 * KBITS; j++) begin
            if (vld_r[j-1]) begin
                vld_s[j] = 1'b1;
                a_s[j]   = a_r[j-1];
                tag_s[j] = tag_r[j-1];
`ifdef MODSMUL_NEG_EN
                neg_s[j] = neg_r[j-1];
`endif
                if (j[0] == 1'b1) begin
                    acc_s[j] = mod_add(acc_r[j-1], acc_r[j-1]);
                    k_s[j]   = k_r[j-1];
                end else begin
                    k_s[j] = k_r[j-1] << 1;
                    if (k_r[j-1][KBITS-1]) begin
                        acc_s[j] = mod_add(acc_r[j-1], a_r[j-1]);
                    end else begin
                        acc_s[j] = acc_r[j-1];
                    end
                end
            end else begin
                vld_s[j] = 1'b0;
            end
        end
`ifdef MODSMUL_NEG_EN
        if (vld_r[NS-2]) begin
            vld_s[NS-1] = 1'b1;
            a_s[NS-1]   = a_r[NS-2];
            k_s[NS-1]   = k_r[NS-2];
            tag_s[NS-1] = tag_r[NS-2];
            neg_s[NS-1] = neg_r[NS-2];
            if (neg_r[NS-2] && (acc_r[NS-2] != {W{1'b0}})) begin
                acc_s[NS-1] = P - acc_r[NS-2];
            end else begin
                acc_s[NS-1] = acc_r[NS-2];
            end
        end else begin
            vld_s[NS-1] = 1'b0;
        end
`endif
    end

    // Stage registers: cleared by reset, frozen as a whole while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NS; j++) begin
                vld_r[j] <= 1'b0;
                acc_r[j] <= {W{1'b0}};
                a_r[j]   <= {W{1'b0}};
                k_r[j]   <= {KBITS{1'b0}};
                tag_r[j] <= {TAGW{1'b0}};
`ifdef MODSMUL_NEG_EN
                neg_r[j] <= 1'b0;
`endif
            end
        end else if (!stall_s) begin
            for (int j = 0; j < NS; j++) begin
                vld_r[j] <= vld_s[j];
                acc_r[j] <= acc_s[j];
                a_r[j]   <= a_s[j];
                k_r[j]   <= k_s[j];
                tag_r[j] <= tag_s[j];
`ifdef MODSMUL_NEG_EN
                neg_r[j] <= neg_s[j];
`endif
            end
        end
    end

endmodule

// File: tb/tb_modsmul_pipe.sv
// Scoreboard bench for modsmul_pipe: W=8/P=97/KBITS=2 directed + stream + stall + reset,
// and a second W=8/P=251/KBITS=3 instance swept exhaustively.
module tb_modsmul_pipe;
`ifdef MODSMUL_NEG_EN
    localparam int LAT0 = 6;
    localparam int LAT1 = 8;
`else
    localparam int LAT0 = 5;
    localparam int LAT1 = 7;
`endif

    typedef struct {
        logic [7:0] data;
        logic [5:0] tag;
        int         cyc;
        bit         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       q0[$];
    exp_t       q1[$];

    logic       in_valid, in_ready, in_neg, out_valid, out_ready;
    logic [7:0] in_a, out_data;
    logic [1:0] in_k;
    logic [5:0] in_tag, out_tag;

    logic       in1_valid, in1_ready, out1_valid;
    logic [7:0] in1_a, out1_data;
    logic [2:0] in1_k;
    logic [5:0] in1_tag, out1_tag;

    modsmul_pipe #(.W(8), .P(8'd97), .KBITS(2), .TAGW(6), .THRES(160)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_k(in_k), .in_neg(in_neg), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag));

    modsmul_pipe #(.W(8), .P(8'd251), .KBITS(3), .TAGW(6), .THRES(160)) u1 (
        .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready), .in_a(in1_a),
        .in_k(in1_k), .in_neg(1'b0), .in_tag(in1_tag), .out_valid(out1_valid),
        .out_ready(1'b1), .out_data(out1_data), .out_tag(out1_tag));

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for u0: pop and compare on every output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q0.size() == 0) begin
                check("u0_unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("u0_data", int'(out_data), int'(e.data));
                check("u0_tag", int'(out_tag), int'(e.tag));
                if (e.lat) check("u0_latency", cyc, e.cyc);
            end
        end
    end

    // Monitor for u1
    always @(negedge clk) begin
        if (!rst && out1_valid) begin
            if (q1.size() == 0) begin
                check("u1_unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("u1_data", int'(out1_data), int'(e.data));
                check("u1_tag", int'(out1_tag), int'(e.tag));
                if (e.lat) check("u1_latency", cyc, e.cyc);
            end
        end
    end

    // Present one operand to u0 until accepted; exp is the expected result
    task automatic send0(input int a, input int k, input bit neg, input int tag,
                         input int exp, input bit push, input bit lat);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        in_a     = 8'(a);
        in_k     = 2'(k);
        in_neg   = neg;
        in_tag   = 6'(tag);
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
        end
        if (n == 100) check("u0_accept_timeout", 0, 1);
        if (push) begin
            e.data = 8'(exp);
            e.tag  = 6'(tag);
            e.cyc  = cyc + LAT0;
            e.lat  = lat;
            q0.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    function automatic int model0(input int a, input int k, input bit neg);
        int r;
        r = (k * a) % 97;
`ifdef MODSMUL_NEG_EN
        if (neg) r = (97 - r) % 97;
`endif
        return r;
    endfunction

    task automatic drain();
        for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        #1;
        check("u0_drain", q0.size(), 0);
        check("u1_drain", q1.size(), 0);
    endtask

    initial begin
        int hold_d, hold_t, w;
        rst = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; in_a = 8'd0; in_k = 2'd0; in_neg = 1'b0; in_tag = 6'd0;
        in1_valid = 1'b0; in1_a = 8'd0; in1_k = 3'd0; in1_tag = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_tag", int'(out_tag), 0);
        check("reset_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors with hand-computed results
        send0(50, 3, 1'b0, 5, 53, 1'b1, 1'b1);
        send0(96, 3, 1'b0, 6, 94, 1'b1, 1'b1);
        send0(0, 3, 1'b0, 7, 0, 1'b1, 1'b1);
        send0(40, 0, 1'b0, 8, 0, 1'b1, 1'b1);
        send0(77, 1, 1'b0, 9, 77, 1'b1, 1'b1);
        send0(96, 2, 1'b0, 10, 95, 1'b1, 1'b1);
        in_valid = 1'b0;
        drain();

        // Back-to-back random stream
        for (int i = 0; i < 20; i++) begin
            int a, k;
            bit n;
            a = $urandom_range(96);
            k = $urandom_range(3);
            n = 1'b0;
`ifdef MODSMUL_NEG_EN
            n = 1'($urandom_range(1));
`endif
            send0(a, k, n, i + 20, model0(a, k, n), 1'b1, 1'b1);
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: hold out_ready low for 3 cycles while a result is waiting
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int a, k;
                    a = $urandom_range(96);
                    k = $urandom_range(3);
                    send0(a, k, 1'b0, i + 45, model0(a, k, 1'b0), 1'b1, 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                for (w = 0; w < 50 && !out_valid; w++) begin
                    @(posedge clk); #1;
                end
                check("bp_saw_valid", int'(out_valid), 1);
                hold_d = int'(out_data);
                hold_t = int'(out_tag);
                out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", int'(in_ready), 0);
                    check("bp_valid_held", int'(out_valid), 1);
                    check("bp_data_held", int'(out_data), hold_d);
                    check("bp_tag_held", int'(out_tag), hold_t);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operands in flight: none may emerge
        send0(50, 3, 1'b0, 1, 0, 1'b0, 1'b0);
        send0(60, 2, 1'b0, 2, 0, 1'b0, 1'b0);
        send0(70, 1, 1'b0, 3, 0, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < LAT0 + 1; c++) begin
            @(negedge clk);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_data", int'(out_data), 0);
            check("rst_out_tag", int'(out_tag), 0);
        end
        @(posedge clk); #1;

`ifdef MODSMUL_NEG_EN
        send0(50, 3, 1'b1, 11, 44, 1'b1, 1'b1);
        send0(0, 2, 1'b1, 12, 0, 1'b1, 1'b1);
        send0(1, 1, 1'b1, 13, 96, 1'b1, 1'b1);
        in_valid = 1'b0;
        drain();
`endif

        // Exhaustive sweep of the P=251, KBITS=3 instance
        in1_valid = 1'b1;
        for (int a = 0; a < 251; a++) begin
            for (int k = 0; k < 8; k++) begin
                exp_t e;
                in1_a   = 8'(a);
                in1_k   = 3'(k);
                in1_tag = 6'(a + k);
                @(negedge clk);
                check("u1_in_ready", int'(in1_ready), 1);
                e.data = 8'((k * a) % 251);
                e.tag  = 6'(a + k);
                e.cyc  = cyc + LAT1;
                e.lat  = 1'b1;
                q1.push_back(e);
                @(posedge clk); #1;
            end
        end
        in1_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
